access_code_tx: RTL

ACCESS_CODE_TX -- requirements
Module: access_code_tx

---
 rtl/access_code_tx_pkg.sv | 25 ++
 rtl/tx_slot_timer.sv | 49 ++++
 rtl/access_code_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/access_code_tx_pkg.sv
`default_nettype none
// ============================================================================
// access_code_tx_pkg -- shared FSM state type and frame constants
// Rev 1.0
// ============================================================================
package access_code_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    PREAMBLE = 3'd2,
    SYNC     = 3'd3,
    TRAILER  = 3'd4
  } tx_state_e;

  localparam int PREAMBLE_LEN = 4;
  localparam int SYNC_LEN     = 64;
  localparam int TRAILER_LEN  = 4;
  localparam int SLOT_US      = 625;

  localparam int BIT_CNT_W  = 7;
  localparam int SLOT_CNT_W = 10;

endpackage
`default_nettype wire

// File: rtl/tx_slot_timer.sv
`default_nettype none
// ============================================================================
// tx_slot_timer -- one-shot 625 us slot timer counting p_1us ticks
// Rev 1.0
// ============================================================================
module tx_slot_timer
  import access_code_tx_pkg::*;
(
  input  logic clk_6M,
  input  logic rstz,
  input  logic start,
  input  logic stop,
  input  logic p_1us,
  output logic tslot_endp
);

  localparam logic [SLOT_CNT_W-1:0] SLOT_LAST = SLOT_CNT_W'(SLOT_US - 1);

  logic [SLOT_CNT_W-1:0] count;
  logic                  running;

  // start lands on a p_1us clk, so that tick is microsecond 0 of the slot
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      count      <= '0;
      running    <= 1'b0;
      tslot_endp <= 1'b0;
    end else begin
      tslot_endp <= 1'b0;
      if (stop) begin
        count   <= '0;
        running <= 1'b0;
      end else if (start) begin
        count   <= '0;
        running <= 1'b1;
      end else if (running && p_1us) begin
        if (count == SLOT_LAST) begin
          count      <= '0;
          running    <= 1'b0;
          tslot_endp <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/access_code_tx.sv
`default_nettype none
// ============================================================================
// access_code_tx -- serialises preamble, 64-bit sync word and optional trailer
// Rev 1.0
// ============================================================================
module access_code_tx
  import access_code_tx_pkg::*;
(
  input  logic                clk_6M,
  input  logic                rstz,
  input  logic                p_1us,
  input  logic                tx_start,
  input  logic                tx_abort,
  input  logic [SYNC_LEN-1:0] tx_sync,
  input  logic                tx_trailer_en,
  output logic                tx_bit,
  output logic                tx_valid,
  output logic                tx_busy,
  output logic                tx_sync_endp,
  output logic                tx_done_p,
  output logic                tx_tslot_endp
);

  localparam logic [BIT_CNT_W-1:0] PRE_LAST  = BIT_CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [BIT_CNT_W-1:0] SYNC_LAST = BIT_CNT_W'(SYNC_LEN - 1);
  localparam logic [BIT_CNT_W-1:0] TRL_LAST  = BIT_CNT_W'(TRAILER_LEN - 1);

  tx_state_e            state, next_state;
  logic [BIT_CNT_W-1:0] bit_cnt, cnt_nxt;
  logic [SYNC_LEN-1:0]  sync_reg;
  logic                 trailer_reg;
  logic                 bit_nxt, valid_nxt, busy_nxt, sync_endp_nxt, done_nxt;
  logic                 capture, abort_hit, frame_end, slot_start, slot_stop;

  assign capture   = (state == IDLE) && tx_start && !tx_abort;
  assign abort_hit = (state != IDLE) && tx_abort;
  assign frame_end = p_1us &&
                     (((state == SYNC) && (bit_cnt == SYNC_LAST) && !trailer_reg) ||
                      ((state == TRAILER) && (bit_cnt == TRL_LAST)));

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      sync_reg     <= '0;
      trailer_reg  <= 1'b0;
      tx_bit       <= 1'b0;
      tx_valid     <= 1'b0;
      tx_busy      <= 1'b0;
      tx_sync_endp <= 1'b0;
      tx_done_p    <= 1'b0;
    end else begin
      state        <= next_state;
      bit_cnt      <= cnt_nxt;
      tx_bit       <= bit_nxt;
      tx_valid     <= valid_nxt;
      tx_busy      <= busy_nxt;
      tx_sync_endp <= sync_endp_nxt;
      tx_done_p    <= done_nxt;
      if (capture) begin
        sync_reg    <= tx_sync;
        trailer_reg <= tx_trailer_en;
      end
    end
  end

  always_comb begin
    next_state = state;
    if (abort_hit) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (capture) next_state = ARMED;
        ARMED:    if (p_1us) next_state = PREAMBLE;
        PREAMBLE: if (p_1us && (bit_cnt == PRE_LAST)) next_state = SYNC;
        SYNC:     if (p_1us && (bit_cnt == SYNC_LAST)) next_state = trailer_reg ? TRAILER : IDLE;
        TRAILER:  if (p_1us && (bit_cnt == TRL_LAST)) next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  // Registered outputs are computed here as next values and loaded with the state
  always_comb begin
    cnt_nxt       = bit_cnt;
    bit_nxt       = tx_bit;
    valid_nxt     = tx_valid;
    busy_nxt      = tx_busy;
    sync_endp_nxt = !abort_hit && p_1us && (state == SYNC) && (bit_cnt == SYNC_LAST);
    done_nxt      = 1'b0;
    slot_start    = 1'b0;
    slot_stop     = 1'b0;

    if (next_state != state)
      cnt_nxt = '0;
    else if (p_1us && (state inside {PREAMBLE, SYNC, TRAILER}))
      cnt_nxt = bit_cnt + 1'b1;

    if (abort_hit) begin
      bit_nxt   = 1'b0;
      valid_nxt = 1'b0;
      busy_nxt  = 1'b0;
      slot_stop = 1'b1;
    end else if (frame_end) begin
      bit_nxt   = 1'b0;
      valid_nxt = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b1;
    end else if (capture) begin
      busy_nxt = 1'b1;
    end else if (p_1us) begin
      case (state)
        ARMED: begin
          bit_nxt    = sync_reg[0];
          valid_nxt  = 1'b1;
          slot_start = 1'b1;
        end
        PREAMBLE: bit_nxt = (bit_cnt == PRE_LAST) ? sync_reg[0] : ~tx_bit;
        SYNC:     bit_nxt = (bit_cnt == SYNC_LAST) ? ~sync_reg[SYNC_LEN-1]
                                                   : sync_reg[bit_cnt[5:0] + 6'd1];
        TRAILER:  bit_nxt = ~tx_bit;
        default:  bit_nxt = tx_bit;
      endcase
    end
  end

  tx_slot_timer u_slot_timer (
    .clk_6M     (clk_6M),
    .rstz       (rstz),
    .start      (slot_start),
    .stop       (slot_stop),
    .p_1us      (p_1us),
    .tslot_endp (tx_tslot_endp)
  );

endmodule
`default_nettype wire
